// File: rtl/priority_grant_queue_if.sv
// Request/grant bundle for priority_grant_queue: request lines, enable mask,
// the granted index with its valid/ready handshake, and status outputs.
interface priority_grant_queue_if #(
    parameter int N    = 8,
    parameter int IDXW = $clog2(N)
);
    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            out_ready;
    logic            out_valid;
    logic [IDXW-1:0] out_idx;
    logic [N-1:0]    pending;
    logic            overflow;

    // master: the request sources and the consumer of grants
    modport master (
        output req, mask, out_ready,
        input  out_valid, out_idx, pending, overflow
    );

    // slave: the arbiter itself
    modport slave (
        input  req, mask, out_ready,
        output out_valid, out_idx, pending, overflow
    );
endinterface

// File: rtl/priority_grant_queue.sv
// Sticky-pending request arbiter: latches request pulses, masks them, and hands
// out one winner index at a time over valid/ready (fixed priority or round-robin).
module priority_grant_queue #(
    parameter int N     = 8,
    parameter int IDXW  = $clog2(N),
    parameter bit RR_EN = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    priority_grant_queue_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic [IDXW-1:0] last_grant_q, last_grant_d;
    logic            overflow_q, overflow_d;

    logic [N-1:0]    clr;
    logic [N-1:0]    elig;
    logic            accept;
    logic            any_elig;
    logic [IDXW-1:0] winner;
    logic            found;
    int              scan_start;
    int              cand;
    logic [IDXW-1:0] cand_idx;

    assign accept   = (state_q == HOLD) && bus.out_ready;
    assign elig     = pending_q & bus.mask;
    assign any_elig = |elig;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_clr
            assign clr[gi] = accept && (out_idx_q == IDXW'(gi));
        end
    endgenerate

    // Descending scan from scan_start with wrap; in fixed mode the scan simply
    // starts at N-1. Starting one below last_grant makes the served line last.
    always_comb begin
        winner     = '0;
        found      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        scan_start = RR_EN ? (int'(last_grant_q) + N - 1) : (N - 1);
        for (int k = 0; k < N; k++) begin
            cand     = (scan_start - k) % N;
            cand_idx = IDXW'(cand);
            if (!found && elig[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end

    // A new request on the bit being cleared wins, so it is never lost.
    always_comb begin
        state_d      = state_q;
        out_idx_d    = out_idx_q;
        last_grant_d = last_grant_q;
        pending_d    = (pending_q & ~clr) | bus.req;
        overflow_d   = |(bus.req & pending_q & ~clr);
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    out_idx_d = winner;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    last_grant_d = out_idx_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            out_idx_q    <= '0;
            last_grant_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            out_idx_q    <= out_idx_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_idx   = out_idx_q;
    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_priority_grant_queue.sv
// Directed bench for priority_grant_queue: one fixed-priority and one round-robin
// instance, hand-computed expectations, plus a running hash of accepted indices.
module tb_priority_grant_queue;
    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] obs_hash = 32'h1234_5678;

    always #5 clk = ~clk;

    priority_grant_queue_if #(.N(8)) f_if ();
    priority_grant_queue_if #(.N(8)) r_if ();

    priority_grant_queue #(.N(8), .RR_EN(1'b0)) dut_fix (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (f_if.slave)
    );

    priority_grant_queue #(.N(8), .RR_EN(1'b1)) dut_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (r_if.slave)
    );

    function automatic logic [31:0] hash_step(input logic [31:0] h, input logic [2:0] idx);
        return {h[26:0], h[31:27]} ^ {29'd0, idx};
    endfunction

    // Accepted grants of the fixed-priority instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && f_if.out_valid && f_if.out_ready)
            obs_hash = hash_step(obs_hash, f_if.out_idx);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("chk %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  exp_grants [5] = '{3'd5, 3'd2, 3'd6, 3'd7, 3'd4};
    logic [31:0] exp_hash;

    initial begin
        reset_n     = 1'b0;
        f_if.req    = 8'hFF;
        f_if.mask   = 8'hFF;
        f_if.out_ready = 1'b0;
        r_if.req    = 8'h00;
        r_if.mask   = 8'hFF;
        r_if.out_ready = 1'b0;

        // 1: reset holds everything clear despite requests
        repeat (3) step();
        reset_n  = 1'b1;
        f_if.req = 8'h00;
        check_eq("rst_pending",  32'(f_if.pending),   32'h00);
        check_eq("rst_valid",    32'(f_if.out_valid), 32'h0);
        check_eq("rst_idx",      32'(f_if.out_idx),   32'h0);
        check_eq("rst_overflow", 32'(f_if.overflow),  32'h0);
        step();
        check_eq("rst_pending2", 32'(f_if.pending),   32'h00);

        // 2: fixed priority, two requests in one pulse
        f_if.out_ready = 1'b1;
        f_if.req = 8'b0010_0100;
        step();
        f_if.req = 8'h00;
        check_eq("fx_pend_set",  32'(f_if.pending),   32'h24);
        check_eq("fx_valid_lat", 32'(f_if.out_valid), 32'h0);
        step();
        check_eq("fx_valid_a",   32'(f_if.out_valid), 32'h1);
        check_eq("fx_idx_a",     32'(f_if.out_idx),   32'd5);
        step();
        check_eq("fx_bubble",    32'(f_if.out_valid), 32'h0);
        check_eq("fx_pend_mid",  32'(f_if.pending),   32'h04);
        step();
        check_eq("fx_valid_b",   32'(f_if.out_valid), 32'h1);
        check_eq("fx_idx_b",     32'(f_if.out_idx),   32'd2);
        step();
        check_eq("fx_pend_end",  32'(f_if.pending),   32'h00);

        // 3: backpressure holds the grant; re-request of 6 overflows
        f_if.out_ready = 1'b0;
        f_if.req = 8'h40;
        step();
        f_if.req = 8'h00;
        step();
        check_eq("bp_idx_first", 32'(f_if.out_idx),   32'd6);
        f_if.req = 8'hC0;
        step();
        f_if.req = 8'h00;
        check_eq("bp_overflow",  32'(f_if.overflow),  32'h1);
        check_eq("bp_pend",      32'(f_if.pending),   32'hC0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("bp_hold_idx",   32'(f_if.out_idx),   32'd6);
            check_eq("bp_hold_valid", 32'(f_if.out_valid), 32'h1);
        end
        check_eq("bp_ovf_pulse", 32'(f_if.overflow),  32'h0);
        f_if.out_ready = 1'b1;
        step();
        check_eq("bp_accept",    32'(f_if.out_valid), 32'h0);
        check_eq("bp_pend_7",    32'(f_if.pending),   32'h80);
        step();
        check_eq("bp_idx_7",     32'(f_if.out_idx),   32'd7);
        step();
        f_if.out_ready = 1'b0;
        check_eq("bp_pend_end",  32'(f_if.pending),   32'h00);

        // 4: round-robin with a held request on lines 7 and 0
        r_if.out_ready = 1'b1;
        r_if.req = 8'h81;
        step();
        check_eq("rr_pend",      32'(r_if.pending),   32'h81);
        check_eq("rr_ovf0",      32'(r_if.overflow),  32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("rr_valid",   32'(r_if.out_valid), 32'h1);
            check_eq("rr_idx",     32'(r_if.out_idx),   (k % 2 == 0) ? 32'd7 : 32'd0);
            check_eq("rr_ovf",     32'(r_if.overflow),  32'h1);
            step();
            check_eq("rr_bubble",  32'(r_if.out_valid), 32'h0);
        end
        r_if.req = 8'h00;
        step();
        check_eq("rr_idx_tail",  32'(r_if.out_idx),   32'd7);
        check_eq("rr_ovf_end",   32'(r_if.overflow),  32'h0);
        repeat (3) step();
        check_eq("rr_drain",     32'(r_if.pending),   32'h00);
        r_if.out_ready = 1'b0;

        // 5: masked line stays pending, granted once unmasked
        f_if.mask = 8'hEF;
        f_if.req  = 8'h10;
        step();
        f_if.req  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("mk_no_valid", 32'(f_if.out_valid), 32'h0);
        end
        check_eq("mk_pend",      32'(f_if.pending),   32'h10);
        f_if.mask = 8'hFF;
        step();
        check_eq("mk_valid",     32'(f_if.out_valid), 32'h1);
        check_eq("mk_idx",       32'(f_if.out_idx),   32'd4);
        f_if.out_ready = 1'b1;
        step();
        f_if.out_ready = 1'b0;
        check_eq("mk_pend_end",  32'(f_if.pending),   32'h00);

        // 6: reset in the middle of a held grant
        f_if.req = 8'h08;
        step();
        f_if.req = 8'h00;
        step();
        check_eq("mr_idx",       32'(f_if.out_idx),   32'd3);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_eq("mr_valid",     32'(f_if.out_valid), 32'h0);
        check_eq("mr_pending",   32'(f_if.pending),   32'h00);
        check_eq("mr_idx_rst",   32'(f_if.out_idx),   32'h0);
        repeat (2) step();
        check_eq("mr_stay_idle", 32'(f_if.out_valid), 32'h0);

        exp_hash = 32'h1234_5678;
        for (int i = 0; i < 5; i++) exp_hash = hash_step(exp_hash, exp_grants[i]);
        check_eq("grant_hash", obs_hash, exp_hash);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
